// File: rtl/nibble_serial_pkg.sv
// Shared types and helpers for the nibble-serial adder/subtractor.
package nibble_serial_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Signed extreme for a given width: min when neg=1, max otherwise.
  function automatic logic [63:0] sat_value(input logic neg, input int width);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_slice.sv
// Combinational 4-bit adder slice; also exposes the carry into bit 3 so the
// caller can form signed overflow on the most significant digit.
module addsub4_slice
  import nibble_serial_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               c3
);

  logic [DIGIT_W-1:0] low;
  logic [1:0]         high;

  always_comb begin
    low  = {1'b0, a[DIGIT_W-2:0]} + {1'b0, b[DIGIT_W-2:0]} + {{(DIGIT_W-1){1'b0}}, cin};
    c3   = low[DIGIT_W-1];
    high = {1'b0, a[DIGIT_W-1]} + {1'b0, b[DIGIT_W-1]} + {1'b0, c3};
    sum  = {high[0], low[DIGIT_W-2:0]};
    cout = high[1];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one 4-bit digit per clock, LSB digit first.
// Define ADDSUB_SAT_EN to clamp overflowing results to the signed extremes.
module nibble_serial_addsub
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS);

  generate
    if ((WIDTH % DIGIT_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   res_reg;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   final_sum;
  logic               carry_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [DIGIT_W-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_c3;

  addsub4_slice u_slice (
    .a    (a_reg[DIGIT_W-1:0]),
    .b    (b_reg[DIGIT_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // New digits enter at the top so the LSB digit lands at bit 0 after DIGITS shifts.
  assign res_next = {slice_sum, res_reg[WIDTH-1:DIGIT_W]};

`ifdef ADDSUB_SAT_EN
  // On overflow the wrapped sign is inverted, so the true sign is ~slice_sum[MSB].
  always_comb begin
    final_sum = res_next;
    if (slice_c3 ^ slice_cout) begin
      final_sum = WIDTH'(sat_value(~slice_sum[DIGIT_W-1], WIDTH));
    end
  end
`else
  assign final_sum = res_next;
`endif

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (count_reg == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: invert B here, the +1 enters as the first carry.
            a_reg     <= in_a;
            b_reg     <= in_b ^ {WIDTH{in_sub}};
            carry_reg <= in_sub;
            count_reg <= CNT_W'(DIGITS - 1);
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT_W;
          b_reg     <= b_reg >> DIGIT_W;
          res_reg   <= res_next;
          carry_reg <= slice_cout;
          if (count_reg == '0) begin
            out_sum  <= final_sum;
            out_cout <= slice_cout;
            out_ovf  <= slice_c3 ^ slice_cout;
          end else begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub (WIDTH=16); honours ADDSUB_SAT_EN.
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endfunction

  // Monitor: pops one expectation per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_sum), 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("result_sum", 32'(out_sum), 32'(e.sum));
          check("result_cout", 32'(out_cout), 32'(e.cout));
          check("result_ovf", 32'(out_ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic [15:0] es, input logic ec, input logic ev, input bit push);
    int t;
    t = 0;
    while (!in_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    if (push) exp_q.push_back('{es, ec, ev});
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("latency", 32'(t), 32'd4);
    t = 0;
    while (out_valid && out_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (out_ready) check("release_cycles", 32'(t), 32'd1);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[8] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_sum", 32'(out_sum), 32'd0);
    check("reset_out_cout", 32'(out_cout), 32'd0);
    check("reset_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1);
      check("in_ready_in_run", 32'(in_ready), 32'd0);
      wait_result();
    end

    // Backpressure: hold the result while new operands are offered.
    out_ready = 1'b0;
    issue(16'hAAAA, 16'h1111, 1'b0, 16'hBBBB, 1'b0, 1'b0, 1'b1);
    wait_result();
    in_a     = 16'h0F0F;
    in_b     = 16'h0101;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_sum", 32'(out_sum), 32'h0000_BBBB);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Abort: reset two clocks after an accept discards the operation.
    issue(16'h2222, 16'h3333, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    wait_result();

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
